mips_state_dumper: RTL and testbench
====================================

// Module: mips_state_dumper
// PURPOSE
//  Read-side counterpart to the program/data preload path of MIPS_32. Once the core halts, it reads
//  the register file and a memory window, then streams them out on a valid/ready word stream.
//  Sits beside MIPS_32 on the debug read ports. Replaces hierarchical peeks when checking results.
// PARAMETERS
//  DATA_W   32  word width of regfile, memory and stream
//  REG_CNT  32  registers dumped, read in order R0..R(REG_CNT-1)
//  MEM_AW   10  memory word-address width; addresses wrap modulo 2**MEM_AW
// PORTS
//  clk1         in   1          single clock, all state updates on posedge
//  rst          in   1          synchronous, active-high reset
//  halted       in   1          core HALTED flag
//  mem_base     in   MEM_AW     first memory word to dump; latched at trigger
//  mem_cnt      in   MEM_AW+1   number of memory words to dump (0..2**MEM_AW); latched at trigger
//  reg_rd_addr  out  5          regfile read address
//  reg_rd_data  in   DATA_W     regfile read data, combinational from reg_rd_addr
//  mem_rd_en    out  1          memory read strobe
//  mem_rd_addr  out  MEM_AW     memory read address
//  mem_rd_data  in   DATA_W     memory read data, valid 1 cycle after mem_rd_en
//  out_valid    out  1          stream word valid
//  out_ready    in   1          stream sink ready
//  out_data     out  DATA_W     stream word
//  out_tag      out  2          0=header 1=register 2=memory 3=trailer
//  out_last     out  1          high on the trailer word only
//  busy         out  1          dump in progress (any state except IDLE/DONE)
//  done         out  1          high in DONE
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0: out_valid, out_data, out_tag, out_last, mem_rd_en, reg_rd_addr,
//    mem_rd_addr, busy, done. Checksum and counters clear. halted_q clears to 0.
//  - Reset mid-dump aborts at once; the next cycle is IDLE with out_valid=0, and no trailer is sent.
//  - Trigger: the cycle where halted=1 and halted_q=0 (halted_q is halted delayed one cycle).
//    On trigger, latch mem_base/mem_cnt and go IDLE->HDR. Triggers outside IDLE are ignored.
//  - Word order: HDR, then REG_CNT register words, then mem_cnt memory words, then TRL.
//    Total words = REG_CNT + mem_cnt + 2.
//  - HDR: out_data = {16'hD0D0, REG_CNT[7:0], mem_cnt[7:0]} (mem_cnt truncated), tag=0.
//    out_valid rises the cycle after trigger.
//  - Payload fetch uses two states per word. FETCH: drive the read address; mem_rd_en=1 for memory
//    words only. PRESENT: capture the data into out_data, assert out_valid, hold until accepted.
//    Minimum 2 cycles per word.
//  - Handshake: a word transfers on a posedge with out_valid & out_ready. While out_valid=1 and
//    out_ready=0, out_data/out_tag/out_last stay stable. out_valid never drops without a transfer.
//  - Register i is read at reg_rd_addr=i, for i = 0..REG_CNT-1.
//  - Memory word k is read at mem_rd_addr = (base+k) mod 2**MEM_AW. mem_cnt=0 skips memory: REGS->TRL.
//  - Checksum: 32-bit wrap-around sum of all register and memory payload words. The header is excluded.
//  - TRL: out_data = checksum, tag=3, out_last=1.
//  - DONE: entered when TRL is accepted. done=1 until halted=0, then return to IDLE.
//  - halted falling during HDR/REGS/MEM/TRL is ignored; the dump always completes.
//  - States: IDLE, HDR, R_FETCH, R_PRES, M_FETCH, M_PRES, TRL, DONE.
// TESTING
//  - Basic dump: regs R[i]=i, mem[120]=85, mem[121]=130, base=120, cnt=2, ready held 1.
//    -> HDR 32'hD0D02002, then words 0..31 with tag 1, then 85 and 130 with tag 2,
//       then TRL 711 with out_last=1. 36 transfers in total.
//  - Backpressure: same setup, out_ready toggles 1,0,0,1 repeatedly.
//    -> identical word sequence; out_data stable while stalled.
//  - Wrap-around: base=1023, cnt=3, mem[1023]=5, mem[0]=6, mem[1]=7.
//    -> memory words 5,6,7 in that order. Checksum = regsum + 18.
//  - Empty window: cnt=0 -> REG_CNT register words go directly to TRL; TRL = 496 with R[i]=i.
//  - Reset mid-dump: rst=1 during register word 10.
//    -> next cycle out_valid=0 and busy=0. A fresh halted 0->1 edge restarts the dump from HDR.
//  - Re-trigger: halted stays 1 after DONE -> no second dump. Drop halted, raise it again -> one new dump.

Source files
------------

// File: rtl/mips_state_dumper.sv
// Post-halt state dumper: streams a header, the register file, a memory window and a checksum
// trailer on a valid/ready word stream once the MIPS_32 core raises its halted flag.
module mips_state_dumper #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32,
    parameter int MEM_AW  = 10
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              halted,
    input  logic [MEM_AW-1:0] mem_base,
    input  logic [MEM_AW:0]   mem_cnt,
    output logic [4:0]        reg_rd_addr,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_tag,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        R_FETCH,
        R_PRES,
        M_FETCH,
        M_PRES,
        TRL,
        DONE
    } state_t;

    localparam logic [4:0]        LAST_REG = 5'(REG_CNT - 1);
    localparam logic [7:0]        REG_CNT8 = 8'(REG_CNT);
    localparam logic [MEM_AW:0]   CNT_ZERO = '0;
    localparam logic [MEM_AW:0]   CNT_ONE  = (MEM_AW + 1)'(1);
    localparam logic [MEM_AW-1:0] ADDR_ONE = MEM_AW'(1);

    state_t              state;
    logic                halted_q;
    logic [MEM_AW-1:0]   base_q;
    logic [MEM_AW:0]     cnt_q;
    logic [DATA_W-1:0]   checksum;

    logic xfer;
    logic trigger;

    assign xfer    = out_valid & out_ready;
    assign trigger = halted & ~halted_q;

    // cnt_q counts down the memory words still to be sent, so it also marks the last one.
    // Memory data arrives the cycle after the M_FETCH strobe, so M_PRES first captures it with
    // out_valid low and only then presents it.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state       <= IDLE;
            halted_q    <= 1'b0;
            base_q      <= '0;
            cnt_q       <= '0;
            checksum    <= '0;
            reg_rd_addr <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_tag     <= 2'd0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            halted_q <= halted;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        base_q    <= mem_base;
                        cnt_q     <= mem_cnt;
                        checksum  <= '0;
                        out_data  <= DATA_W'({16'hD0D0, REG_CNT8, mem_cnt[7:0]});
                        out_tag   <= 2'd0;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        out_valid   <= 1'b0;
                        reg_rd_addr <= '0;
                        state       <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    out_data  <= reg_rd_data;
                    out_tag   <= 2'd1;
                    out_valid <= 1'b1;
                    checksum  <= checksum + reg_rd_data;
                    state     <= R_PRES;
                end
                R_PRES: begin
                    if (xfer) begin
                        if (reg_rd_addr != LAST_REG) begin
                            out_valid   <= 1'b0;
                            reg_rd_addr <= reg_rd_addr + 5'd1;
                            state       <= R_FETCH;
                        end else if (cnt_q == CNT_ZERO) begin
                            out_data  <= checksum;
                            out_tag   <= 2'd3;
                            out_last  <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= TRL;
                        end else begin
                            out_valid   <= 1'b0;
                            mem_rd_addr <= base_q;
                            mem_rd_en   <= 1'b1;
                            state       <= M_FETCH;
                        end
                    end
                end
                M_FETCH: begin
                    mem_rd_en <= 1'b0;
                    state     <= M_PRES;
                end
                M_PRES: begin
                    if (!out_valid) begin
                        out_data  <= mem_rd_data;
                        out_tag   <= 2'd2;
                        out_valid <= 1'b1;
                        checksum  <= checksum + mem_rd_data;
                    end else if (out_ready) begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            out_data <= checksum;
                            out_tag  <= 2'd3;
                            out_last <= 1'b1;
                            state    <= TRL;
                        end else begin
                            out_valid   <= 1'b0;
                            mem_rd_addr <= mem_rd_addr + ADDR_ONE;
                            mem_rd_en   <= 1'b1;
                            state       <= M_FETCH;
                        end
                    end
                end
                TRL: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (!halted) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_state_dumper.sv
// Bench for mips_state_dumper: a queue-based reference model of the dump stream, checked
// against the DUT with fixed, toggling and random sink backpressure.
module tb_mips_state_dumper;

    localparam int DATA_W  = 32;
    localparam int REG_CNT = 32;
    localparam int MEM_AW  = 10;
    localparam int MEM_SZ  = 1 << MEM_AW;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              halted;
    logic [MEM_AW-1:0] mem_base;
    logic [MEM_AW:0]   mem_cnt;
    logic [4:0]        reg_rd_addr;
    logic [DATA_W-1:0] reg_rd_data;
    logic              mem_rd_en;
    logic [MEM_AW-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_tag;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] reg_file [REG_CNT];
    logic [DATA_W-1:0] mem      [MEM_SZ];

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        tag;
        logic              last;
    } word_t;

    word_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    mips_state_dumper #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .MEM_AW(MEM_AW)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .halted     (halted),
        .mem_base   (mem_base),
        .mem_cnt    (mem_cnt),
        .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk1 = ~clk1;

    assign reg_rd_data = reg_file[reg_rd_addr];

    always @(posedge clk1) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    // Expected stream straight from the word-order rules: header, registers, window, sum.
    function automatic void build_expected(input logic [MEM_AW-1:0] base, input int cnt);
        logic [DATA_W-1:0] sum;
        word_t w;
        sum = '0;
        exp_q.delete();
        w.data = {16'hD0D0, 8'(REG_CNT), 8'(cnt)};
        w.tag  = 2'd0;
        w.last = 1'b0;
        exp_q.push_back(w);
        for (int i = 0; i < REG_CNT; i++) begin
            sum = sum + reg_file[i];
            w.data = reg_file[i];
            w.tag  = 2'd1;
            exp_q.push_back(w);
        end
        for (int k = 0; k < cnt; k++) begin
            w.data = mem[(int'(base) + k) % MEM_SZ];
            sum    = sum + w.data;
            w.tag  = 2'd2;
            exp_q.push_back(w);
        end
        w.data = sum;
        w.tag  = 2'd3;
        w.last = 1'b1;
        exp_q.push_back(w);
    endfunction

    task automatic regs_index();
        for (int i = 0; i < REG_CNT; i++) reg_file[i] = DATA_W'(i);
    endtask

    task automatic regs_random();
        for (int i = 0; i < REG_CNT; i++) reg_file[i] = $urandom;
    endtask

    task automatic start_dump(input logic [MEM_AW-1:0] base, input int cnt);
        @(negedge clk1);
        out_ready = 1'b0;
        halted    = 1'b0;
        repeat (2) @(negedge clk1);
        mem_base = base;
        mem_cnt  = (MEM_AW + 1)'(cnt);
        build_expected(base, cnt);
        halted = 1'b1;
        @(negedge clk1);
        vectors++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || out_tag !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL hdr_latency: out_valid=%b busy=%b tag=%0d, required 1 1 0",
                     out_valid, busy, out_tag);
        end
    endtask

    // Drains the expected queue one negedge at a time; mode 0 ready=1, 1 pattern 1,0,0,1,
    // 2 random. abort_at>=0 returns while word number abort_at is being presented.
    task automatic run_dump(input int mode, input int abort_at, output bit aborted);
        int    cycles = 0;
        int    popped = 0;
        int    phase  = 0;
        bit    prev_stall = 1'b0;
        word_t held;
        word_t got;
        aborted = 1'b0;
        held    = '0;
        while (exp_q.size() > 0) begin
            got = {out_data, out_tag, out_last};
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || got !== held) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold: valid=%b data=%h tag=%0d last=%b, required 1 %h %0d %b",
                             out_valid, got.data, got.tag, got.last, held.data, held.tag, held.last);
                end
            end
            if (abort_at >= 0 && popped == abort_at && out_valid === 1'b1) begin
                aborted   = 1'b1;
                out_ready = 1'b0;
                return;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (phase % 4 == 0) || (phase % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            phase++;
            if (out_valid === 1'b1 && out_ready) begin
                vectors++;
                if (got !== exp_q[0]) begin
                    miscompares++;
                    $display("[TB] FAIL word_%0d: data=%h tag=%0d last=%b, required %h %0d %b",
                             popped, got.data, got.tag, got.last,
                             exp_q[0].data, exp_q[0].tag, exp_q[0].last);
                end
                void'(exp_q.pop_front());
                popped++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = (out_valid === 1'b1);
            end
            held = got;
            cycles++;
            if (cycles > 20000) begin
                miscompares++;
                $display("[TB] FAIL dump_timeout: %0d words left, required 0", exp_q.size());
                exp_q.delete();
                break;
            end
            @(negedge clk1);
        end
        out_ready = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL end_state: done=%b busy=%b out_valid=%b, required 1 0 0",
                     done, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        halted    = 1'b0;
        out_ready = 1'b0;
        mem_base  = '0;
        mem_cnt   = '0;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        vectors++;
        if ({out_valid, out_data, out_tag, out_last, mem_rd_en, reg_rd_addr, mem_rd_addr, busy, done} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: valid=%b data=%h tag=%0d last=%b en=%b ra=%0d ma=%0d busy=%b done=%b, required all 0",
                     out_valid, out_data, out_tag, out_last, mem_rd_en, reg_rd_addr, mem_rd_addr, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ab;
        regs_index();
        mem[120] = 32'd85;
        mem[121] = 32'd130;
        start_dump(10'd120, 2);
        vectors++;
        if (exp_q.size() != 36 || exp_q[0].data !== 32'hD0D02002 || exp_q[35].data !== 32'd711) begin
            miscompares++;
            $display("[TB] FAIL basic_model: words=%0d hdr=%h trl=%0d, required 36 d0d02002 711",
                     exp_q.size(), exp_q[0].data, exp_q[35].data);
        end
        run_dump(0, -1, ab);
    endtask

    task automatic test_backpressure();
        bit ab;
        regs_index();
        start_dump(10'd120, 2);
        run_dump(1, -1, ab);
    endtask

    task automatic test_wrap();
        bit ab;
        regs_random();
        mem[1023] = 32'd5;
        mem[0]    = 32'd6;
        mem[1]    = 32'd7;
        start_dump(10'd1023, 3);
        run_dump(2, -1, ab);
    endtask

    task automatic test_empty();
        bit ab;
        regs_index();
        start_dump(10'd77, 0);
        run_dump(1, -1, ab);
    endtask

    task automatic test_random();
        bit ab;
        for (int n = 0; n < 4; n++) begin
            regs_random();
            for (int a = 0; a < MEM_SZ; a++) mem[a] = $urandom;
            start_dump(MEM_AW'($urandom_range(0, MEM_SZ - 1)), (n == 3) ? 300 : int'($urandom_range(1, 40)));
            run_dump(2, -1, ab);
        end
        start_dump(MEM_AW'($urandom_range(0, MEM_SZ - 1)), MEM_SZ);
        run_dump(0, -1, ab);
    endtask

    task automatic test_reset_mid();
        bit ab;
        regs_index();
        start_dump(10'd120, 2);
        run_dump(0, 11, ab);
        vectors++;
        if (ab !== 1'b1 || out_data !== 32'd10 || out_tag !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL abort_point: reached=%b data=%0d tag=%0d, required 1 10 1",
                     ab, out_data, out_tag);
        end
        rst    = 1'b1;
        halted = 1'b0;
        @(posedge clk1);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_abort: out_valid=%b busy=%b done=%b, required 0 0 0",
                     out_valid, busy, done);
        end
        @(negedge clk1);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk1);
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL post_reset_idle: out_valid=%b busy=%b, required 0 0", out_valid, busy);
            end
        end
        start_dump(10'd120, 2);
        run_dump(0, -1, ab);
    endtask

    task automatic test_retrigger();
        bit ab;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk1);
            vectors++;
            if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL held_halt: out_valid=%b done=%b busy=%b, required 0 1 0",
                         out_valid, done, busy);
            end
        end
        halted = 1'b0;
        @(negedge clk1);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_clear: done=%b, required 0", done);
        end
        regs_random();
        start_dump(10'd500, 5);
        run_dump(2, -1, ab);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk1);
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL second_dump: out_valid=%b busy=%b, required 0 0", out_valid, busy);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < MEM_SZ; a++) mem[a] = $urandom;
        regs_index();
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_empty();
        test_random();
        test_reset_mid();
        test_retrigger();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
